// File: rtl/maze_move_ctrl.sv
// -----------------------------------------------------------------------------
// maze_move_ctrl
//
// Sequences player movement through the generated maze. PS/2 set-2 arrow-key
// bytes are decoded into direction requests (L=0, R=1, U=2, D=3) and queued in
// a small FIFO. A three-state FSM (IDLE -> CHECK -> COOL) issues one move at a
// time. Each move is bounds-checked and checked against the maze open/wall bit
// before (curr_x, curr_y) is updated. A cooldown of SLOW_TIME cycles follows
// every issued move.
//
// Optional feature, enabled by defining MAZE_MOVE_HOLD_REPEAT_EN:
//   The decoder tracks the held arrow key and suppresses typematic repeats of
//   it. While the key is held and the FIFO is empty, the held direction is
//   re-issued automatically each time the cooldown expires.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset (highest priority)
//   enable        high = accept keys and issue moves
//   load          1-cycle pulse: reload start position, flush FIFO
//   key_valid     1-cycle strobe qualifying key_code
//   key_code      PS/2 scan byte
//   maze_data     cell (x,y) is open when bit [x+16*y] = 1
//   maze_width    valid columns, 1..16
//   maze_height   valid rows, 1..16
//   start_x/y     start cell
//   goal_x/y      goal cell
//   curr_x/y      current cell
//   at_goal       registered: high while the current cell equals the goal
//   move_done     1-cycle pulse on an accepted move
//   move_blocked  1-cycle pulse on a rejected move
//   move_count    accepted moves since reset/load, saturating
//   fsm_state     debug view of the move FSM (0 IDLE, 1 CHECK, 2 COOL)
//
// Request path handshake: a direction request moves from the decoder into the
// FIFO when push_req (valid) is high and the FIFO is not full (ready). It moves
// from the FIFO into the FSM when the FIFO is non-empty (valid) and the FSM is
// IDLE, enabled and not at the goal (ready). key_valid is a bare strobe with no
// ready, so a request that meets a full FIFO or a disabled block is dropped.
// -----------------------------------------------------------------------------
module maze_move_ctrl #(
    parameter int unsigned SLOW_TIME  = 2500000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  KEY_LEFT   = 8'h6B,
    parameter logic [7:0]  KEY_RIGHT  = 8'h74,
    parameter logic [7:0]  KEY_UP     = 8'h75,
    parameter logic [7:0]  KEY_DOWN   = 8'h72
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic         key_valid,
    input  logic [7:0]   key_code,
    input  logic [255:0] maze_data,
    input  logic [4:0]   maze_width,
    input  logic [4:0]   maze_height,
    input  logic [3:0]   start_x,
    input  logic [3:0]   start_y,
    input  logic [3:0]   goal_x,
    input  logic [3:0]   goal_y,
    output logic [3:0]   curr_x,
    output logic [3:0]   curr_y,
    output logic         at_goal,
    output logic         move_done,
    output logic         move_blocked,
    output logic [15:0]  move_count,
    output logic [1:0]   fsm_state
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(SLOW_TIME + 1);

    localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(SLOW_TIME - 1);

    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // -------------------------------------------------------------------------
    // Key decoder
    // -------------------------------------------------------------------------
    logic       ext_q, brk_q;
    logic       is_e0, is_f0;
    logic       key_match;
    logic [1:0] key_dir;
    logic       make_evt;
    logic       push_req;
    logic [1:0] push_dir;

    assign is_e0 = (key_code == 8'hE0);
    assign is_f0 = (key_code == 8'hF0);

    always_comb begin
        key_match = 1'b1;
        key_dir   = DIR_L;
        if (key_code == KEY_LEFT) begin
            key_dir = DIR_L;
        end else if (key_code == KEY_RIGHT) begin
            key_dir = DIR_R;
        end else if (key_code == KEY_UP) begin
            key_dir = DIR_U;
        end else if (key_code == KEY_DOWN) begin
            key_dir = DIR_D;
        end else begin
            key_match = 1'b0;
        end
    end

    // A completed extended make sequence (E0 <code>) for one of the arrows.
    assign make_evt = key_valid && !is_e0 && !is_f0 && ext_q && !brk_q && key_match;

    // Prefix flags are tracked even while disabled so a sequence that straddles
    // an enable edge is still framed correctly.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (key_valid) begin
            if (is_e0) begin
                ext_q <= 1'b1;
            end else if (is_f0) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Direction FIFO
    // -------------------------------------------------------------------------
    logic [1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic           fifo_empty, fifo_full;
    logic           fifo_flush;
    logic           do_push;
    logic           fifo_pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Disabled or parked on the goal: nothing may be queued.
    assign fifo_flush = !enable || at_goal;
    assign do_push    = push_req && !fifo_full && !fifo_flush && !reset && !load;

    always_ff @(posedge clk) begin
        if (reset || load || fifo_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_dir;
        end
    end

    // -------------------------------------------------------------------------
    // Move FSM: state register / next-state / outputs
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cool_cnt_q;
    logic [1:0]       dir_q;
    logic             check_en;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty && !at_goal) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: state_d = S_COOL;
                S_COOL: begin
                    if (cool_cnt_q == COOL_LAST) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_pop = 1'b0;
        check_en = 1'b0;
        if (enable) begin
            fifo_pop = (state_q == S_IDLE) && !fifo_empty && !at_goal;
            check_en = (state_q == S_CHECK);
        end
    end

    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cool_cnt_q <= '0;
        end else if (enable && state_q == S_COOL && cool_cnt_q != COOL_LAST) begin
            cool_cnt_q <= cool_cnt_q + CNT_ONE;
        end else begin
            cool_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || load) begin
            dir_q <= DIR_L;
        end else if (fifo_pop) begin
            dir_q <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
        end
    end

    // -------------------------------------------------------------------------
    // Push source: plain decoder, or decoder with hold/auto-repeat
    // -------------------------------------------------------------------------
`ifdef MAZE_MOVE_HOLD_REPEAT_EN
    logic       held_q;
    logic [1:0] held_dir_q;
    logic       brk_evt;
    logic       key_push;
    logic       auto_push;
    logic       cool_done;

    assign brk_evt  = key_valid && !is_e0 && !is_f0 && ext_q && brk_q && key_match;
    assign key_push = make_evt && !(held_q && (held_dir_q == key_dir));

    // The cooldown expiring is the moment to re-issue a still-held direction;
    // the same-cycle push makes the FSM see it on its first IDLE cycle.
    assign cool_done = enable && (state_q == S_COOL) && (cool_cnt_q == COOL_LAST);
    assign auto_push = held_q && fifo_empty && cool_done;

    assign push_req = key_push || auto_push;
    assign push_dir = key_push ? key_dir : held_dir_q;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            held_q     <= 1'b0;
            held_dir_q <= DIR_L;
        end else if (make_evt) begin
            held_q     <= 1'b1;
            held_dir_q <= key_dir;
        end else if (brk_evt && held_q && (key_dir == held_dir_q)) begin
            held_q <= 1'b0;
        end
    end
`else
    assign push_req = make_evt;
    assign push_dir = key_dir;
`endif

    // -------------------------------------------------------------------------
    // Target cell evaluation (valid during CHECK)
    // -------------------------------------------------------------------------
    logic [4:0] x5, y5, tx5, ty5;
    logic       out_of_bounds;
    logic [7:0] cell_idx;
    logic       move_ok;

    assign x5 = {1'b0, curr_x};
    assign y5 = {1'b0, curr_y};

    // Bounds are decided in 5-bit arithmetic first; the target coordinate is
    // only meaningful (and only used to index the maze) when in bounds.
    always_comb begin
        tx5           = x5;
        ty5           = y5;
        out_of_bounds = 1'b0;
        case (dir_q)
            DIR_L: begin
                if (x5 == 5'd0) out_of_bounds = 1'b1;
                else            tx5 = x5 - 5'd1;
            end
            DIR_R: begin
                if (x5 + 5'd1 >= maze_width) out_of_bounds = 1'b1;
                else                         tx5 = x5 + 5'd1;
            end
            DIR_U: begin
                if (y5 == 5'd0) out_of_bounds = 1'b1;
                else            ty5 = y5 - 5'd1;
            end
            default: begin
                if (y5 + 5'd1 >= maze_height) out_of_bounds = 1'b1;
                else                          ty5 = y5 + 5'd1;
            end
        endcase
    end

    assign cell_idx = {ty5[3:0], tx5[3:0]};
    assign move_ok  = !out_of_bounds && maze_data[cell_idx];

    // -------------------------------------------------------------------------
    // Position, pulses, counter, goal flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || load) begin
            curr_x       <= start_x;
            curr_y       <= start_y;
            at_goal      <= 1'b0;
            move_done    <= 1'b0;
            move_blocked <= 1'b0;
            move_count   <= 16'd0;
        end else begin
            move_done    <= check_en && move_ok;
            move_blocked <= check_en && !move_ok;
            at_goal      <= (curr_x == goal_x) && (curr_y == goal_y);
            if (check_en && move_ok) begin
                curr_x <= tx5[3:0];
                curr_y <= ty5[3:0];
                if (move_count != 16'hFFFF) begin
                    move_count <= move_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maze_move_ctrl
//
// Scoreboard bench for maze_move_ctrl. Stimulus tasks push the expected outcome
// of every arrow make into exp_q using a grid model (integer coordinates, bounds
// and wall lookup). A monitor pops and compares whenever move_done or
// move_blocked pulses. Directed scenarios add latency, spacing, goal and flush
// checks; a randomized phase exercises random mazes and key streams.
// -----------------------------------------------------------------------------
module tb_maze_move_ctrl;

    localparam int SLOW  = 8;
    localparam int DEPTH = 4;
    localparam int EXP_W = 26;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         load;
    logic         key_valid;
    logic [7:0]   key_code;
    logic [255:0] maze_data;
    logic [4:0]   maze_width;
    logic [4:0]   maze_height;
    logic [3:0]   start_x, start_y, goal_x, goal_y;
    logic [3:0]   curr_x, curr_y;
    logic         at_goal, move_done, move_blocked;
    logic [15:0]  move_count;
    logic [1:0]   fsm_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    maze_move_ctrl #(
        .SLOW_TIME  (SLOW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .maze_data    (maze_data),
        .maze_width   (maze_width),
        .maze_height  (maze_height),
        .start_x      (start_x),
        .start_y      (start_y),
        .goal_x       (goal_x),
        .goal_y       (goal_y),
        .curr_x       (curr_x),
        .curr_y       (curr_y),
        .at_goal      (at_goal),
        .move_done    (move_done),
        .move_blocked (move_blocked),
        .move_count   (move_count),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               done_times[$];
    int               n_cmp = 0;
    int               n_err = 0;

    // ---------------- reference model ----------------
    logic [255:0] m_maze;
    int           mx, my, mcnt, mw, mh, gx, gy;
    bit           m_at_goal;

    function automatic logic [7:0] dir_code(input int d);
        case (d)
            0:       return 8'h6B;
            1:       return 8'h74;
            2:       return 8'h75;
            default: return 8'h72;
        endcase
    endfunction

    // One arrow request applied on the grid; records the expected pulse.
    task automatic model_move(input int dir);
        int nx, ny;
        bit blk;
        if (m_at_goal) return;
        nx = mx;
        ny = my;
        case (dir)
            0:       nx = mx - 1;
            1:       nx = mx + 1;
            2:       ny = my - 1;
            default: ny = my + 1;
        endcase
        blk = (nx < 0) || (nx >= mw) || (ny < 0) || (ny >= mh);
        if (!blk) blk = (m_maze[nx + 16 * ny] == 1'b0);
        if (!blk) begin
            mx = nx;
            my = ny;
            if (mcnt < 65535) mcnt = mcnt + 1;
        end
        exp_q.push_back({~blk, blk, 4'(mx), 4'(my), 16'(mcnt)});
        if (mx == gx && my == gy) m_at_goal = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [EXP_W-1:0] act, e;
        if (reset === 1'b0 && (move_done || move_blocked)) begin
            act = {move_done, move_blocked, curr_x, curr_y, move_count};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_move_event: got %0h expected none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL move_event: got %0h expected %0h", act, e);
                end
            end
            if (move_done) done_times.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
        $fatal(1);
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        key_valid = 1'b1;
        key_code  = b;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic send_make(input int d);
        send_byte(8'hE0);
        send_byte(dir_code(d));
    endtask

    task automatic send_break(input int d);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(dir_code(d));
    endtask

    task automatic send_press(input int d);
        send_make(d);
        send_break(d);
    endtask

    task automatic setup(input int sx, input int sy, input int gxx, input int gyy,
                         input int w, input int h);
        start_x     = 4'(sx);
        start_y     = 4'(sy);
        goal_x      = 4'(gxx);
        goal_y      = 4'(gyy);
        maze_width  = 5'(w);
        maze_height = 5'(h);
        maze_data   = m_maze;
        mw = w; mh = h; gx = gxx; gy = gyy;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        mx = sx; my = sy; mcnt = 0;
        m_at_goal = (sx == gxx) && (sy == gyy);
        tick(2);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_expected_queue", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_move_done(output int lat);
        lat = 1;
        while (!move_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, n_hold;
        reset = 1'b1; enable = 1'b1; load = 1'b0;
        key_valid = 1'b0; key_code = 8'h00;
        m_maze = '1;
        start_x = 4'd2; start_y = 4'd3; goal_x = 4'd15; goal_y = 4'd15;
        maze_data = m_maze; maze_width = 5'd16; maze_height = 5'd16;
        mx = 2; my = 3; mcnt = 0; mw = 16; mh = 16; gx = 15; gy = 15; m_at_goal = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset_curr_x", 32'(curr_x), 32'd2);
        check("reset_curr_y", 32'(curr_y), 32'd3);
        check("reset_at_goal", 32'(at_goal), 32'd0);
        check("reset_move_count", 32'(move_count), 32'd0);
        check("reset_pulses", 32'({move_done, move_blocked}), 32'd0);

        // First move right: key strobe to visible position in three cycles
        model_move(1);
        send_make(1);
        wait_move_done(lat);
        check("latency_strobe_to_move", 32'(lat), 32'd3);
        check("first_move_x", 32'(curr_x), 32'd3);
        check("first_move_count", 32'(move_count), 32'd1);
        send_break(1);
        tick(SLOW + 6);

        // Blocked at the left edge, then blocked by a wall below
        m_maze = '1;
        setup(0, 5, 15, 15, 16, 16);
        model_move(0);
        send_press(0);
        tick(SLOW + 6);
        check("left_edge_x_held", 32'(curr_x), 32'd0);
        m_maze[4 + 16 * 5] = 1'b0;
        setup(4, 4, 15, 15, 16, 16);
        model_move(3);
        send_press(3);
        tick(SLOW + 6);
        check("wall_y_held", 32'(curr_y), 32'd4);
        wait_drain();

        // Burst of six requests: one in flight plus a full FIFO
        m_maze = '1;
        setup(0, 7, 15, 15, 16, 16);
        done_times.delete();
        for (int i = 0; i < 6; i++) begin
`ifdef MAZE_MOVE_HOLD_REPEAT_EN
            if (i < DEPTH + 1) model_move(i % 2);
            send_make(i % 2);
`else
            if (i < DEPTH + 1) model_move(1);
            send_make(1);
`endif
        end
`ifdef MAZE_MOVE_HOLD_REPEAT_EN
        send_break(1);
`else
        send_break(1);
`endif
        wait_drain();
        tick(SLOW * 3);
        check("burst_move_total", 32'(done_times.size()), 32'(DEPTH + 1));
        for (int i = 1; i < done_times.size(); i++)
            check("burst_spacing", 32'(done_times[i] - done_times[i-1]), 32'(SLOW + 2));
        check("burst_final_x", 32'(curr_x), 32'(mx));

        // Reaching the goal, second request discarded, then load
        m_maze = '1;
        setup(4, 0, 5, 0, 16, 16);
        model_move(1);
        send_make(1);
        wait_move_done(lat);
        check("goal_at_goal_not_yet", 32'(at_goal), 32'd0);
        tick(1);
        check("goal_at_goal_registered", 32'(at_goal), 32'd1);
        send_break(1);
        model_move(1);
        send_press(1);
        tick(SLOW + 6);
        check("goal_x_held", 32'(curr_x), 32'd5);
        check("goal_count", 32'(move_count), 32'd1);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        mx = 4; my = 0; mcnt = 0; m_at_goal = 1'b0;
        check("load_curr_x", 32'(curr_x), 32'd4);
        check("load_count", 32'(move_count), 32'd0);
        check("load_at_goal", 32'(at_goal), 32'd0);
        tick(2);

        // Break sequence and unprefixed code push nothing
        setup(2, 9, 15, 15, 16, 16);
        send_break(2);
        send_byte(8'h75);
        tick(SLOW + 6);
        check("nopush_count", 32'(move_count), 32'd0);
        check("nopush_y", 32'(curr_y), 32'd9);

        // Enable dropped mid-cooldown with two requests queued
        model_move(1);
        send_make(1);
        send_make(0);
        send_make(1);
        tick(2);
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        send_break(1);
        tick(SLOW * 4);
        check("enable_flush_x", 32'(curr_x), 32'd3);
        check("enable_flush_count", 32'(move_count), 32'd1);
        wait_drain();

        // Holding right for three cooldown periods
`ifdef MAZE_MOVE_HOLD_REPEAT_EN
        n_hold = 3;
`else
        n_hold = 1;
`endif
        setup(0, 1, 15, 15, 16, 16);
        for (int i = 0; i < n_hold; i++) model_move(1);
        send_make(1);
        tick(3 * (SLOW + 2) - 6);
        send_break(1);
        tick(SLOW * 4);
        check("hold_move_count", 32'(move_count), 32'(n_hold));
        wait_drain();

        // Randomized mazes and key streams
        for (int it = 0; it < 30; it++) begin
            int w, h, sx, sy, gxx, gyy;
            w   = $urandom_range(16, 1);
            h   = $urandom_range(16, 1);
            sx  = $urandom_range(w - 1, 0);
            sy  = $urandom_range(h - 1, 0);
            gxx = $urandom_range(w - 1, 0);
            gyy = $urandom_range(h - 1, 0);
            for (int b = 0; b < 256; b++) m_maze[b] = ($urandom_range(3, 0) != 0);
            setup(sx, sy, gxx, gyy, w, h);
            for (int k = 0; k < 6; k++) begin
                int kind, d;
                kind = $urandom_range(9, 0);
                d    = $urandom_range(3, 0);
                if (kind == 0) begin
                    send_break(d);
                end else if (kind == 1) begin
                    send_byte(dir_code(d));
                end else if (kind == 2) begin
                    send_byte(8'hE0);
                    send_byte(8'h11);
                end else begin
                    model_move(d);
                    send_press(d);
                end
                tick(SLOW + 6);
            end
            wait_drain();
            check("rand_curr_x", 32'(curr_x), 32'(mx));
            check("rand_curr_y", 32'(curr_y), 32'(my));
            check("rand_count", 32'(move_count), 32'(mcnt));
        end

        tick(4);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
